// File: rtl/bt_msg_receiver_if.sv
// bt_msg_receiver_if: serial input, received-byte status and message buffer read port of the BT receiver
interface bt_msg_receiver_if;
  logic       uart_rx;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic       overflow_err;
  logic       msg_valid;
  logic [4:0] msg_len;
  logic [4:0] msg_rd_addr;
  logic [7:0] msg_rd_data;
  logic       msg_ack;
  modport master (
    output uart_rx, msg_rd_addr, msg_ack,
    input  rx_byte, rx_byte_valid, frame_err, overflow_err, msg_valid, msg_len, msg_rd_data
  );
  modport slave (
    input  uart_rx, msg_rd_addr, msg_ack,
    output rx_byte, rx_byte_valid, frame_err, overflow_err, msg_valid, msg_len, msg_rd_data
  );
endinterface

// File: rtl/bt_msg_receiver.sv
// bt_msg_receiver: 8N1 UART receiver plus '#'-terminated message assembler with an addressable buffer
module bt_msg_receiver #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] TERM_CHAR    = 8'h23
) (
  input logic clk_50M,
  input logic rst,
  bt_msg_receiver_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] MAX_C = 5'(MAX_LEN);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_t;
  typedef enum logic [1:0] {A_COLLECT, A_DISCARD, A_HOLD} asm_t;
  logic [1:0] r_sync, r_live;
  logic r_prev;
  logic w_rx, w_fall;
  rx_t r_rx_st, w_rx_nx;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_data, r_byte;
  logic r_byte_valid, r_frame_err;
  logic w_half, w_full, w_cnt_clr, w_shift, w_ok, w_bad;
  asm_t r_asm_st, w_asm_nx;
  logic [4:0] r_count, r_len;
  logic [7:0] r_buf [32];
  logic [7:0] r_rd_data;
  logic r_msg_valid, r_ovf;
  logic w_acc, w_term, w_full_buf, w_wr, w_ovf, w_latch, w_cnt_zero;
  // r_live masks the preset synchroniser output so a line held low out of reset cannot fake an edge
  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_live <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], bus.uart_rx};
      r_live <= {r_live[0], 1'b1};
      r_prev <= w_rx & r_live[1];
    end
  end
  always_ff @(posedge clk_50M) r_rx_st <= rst ? S_IDLE : w_rx_nx;
  assign w_half = r_cnt == HALF_M1;
  assign w_full = r_cnt == FULL_M1;
  always_comb begin
    w_rx_nx = r_rx_st;
    unique case (r_rx_st)
      S_IDLE:  w_rx_nx = w_fall ? S_START : S_IDLE;
      S_START: w_rx_nx = w_half ? (w_rx ? S_IDLE : S_DATA) : S_START;
      S_DATA:  w_rx_nx = (w_full && r_bit == 3'd7) ? S_STOP : S_DATA;
      S_STOP:  w_rx_nx = w_full ? S_IDLE : S_STOP;
      default: w_rx_nx = S_IDLE;
    endcase
  end
  always_comb begin
    w_shift   = r_rx_st == S_DATA && w_full;
    w_ok      = r_rx_st == S_STOP && w_full && w_rx;
    w_bad     = r_rx_st == S_STOP && w_full && !w_rx;
    w_cnt_clr = r_rx_st == S_IDLE || (r_rx_st == S_START && w_half) || w_full;
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_data       <= 8'h00;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_bit        <= r_rx_st == S_DATA ? r_bit + 3'(w_shift) : 3'd0;
      r_data       <= w_shift ? {w_rx, r_data[7:1]} : r_data;
      r_byte       <= w_ok ? r_data : r_byte;
      r_byte_valid <= w_ok;
      r_frame_err  <= w_bad;
    end
  end
  assign w_acc      = r_byte_valid;
  assign w_term     = r_byte == TERM_CHAR;
  assign w_full_buf = r_count == MAX_C;
  always_ff @(posedge clk_50M) r_asm_st <= rst ? A_COLLECT : w_asm_nx;
  always_comb begin
    w_asm_nx = r_asm_st;
    unique case (r_asm_st)
      A_COLLECT: w_asm_nx = !w_acc ? A_COLLECT :
                            (w_term && r_count != 5'd0) ? A_HOLD :
                            (!w_term && w_full_buf) ? A_DISCARD : A_COLLECT;
      A_DISCARD: w_asm_nx = (w_acc && w_term) ? A_COLLECT : A_DISCARD;
      A_HOLD:    w_asm_nx = bus.msg_ack ? A_COLLECT : A_HOLD;
      default:   w_asm_nx = A_COLLECT;
    endcase
  end
  // A byte arriving with msg_ack in HOLD is still counted as dropped
  always_comb begin
    w_wr       = r_asm_st == A_COLLECT && w_acc && !w_term && !w_full_buf;
    w_latch    = r_asm_st == A_COLLECT && w_acc && w_term && r_count != 5'd0;
    w_ovf      = w_acc && ((r_asm_st == A_COLLECT && !w_term && w_full_buf) || r_asm_st == A_HOLD);
    w_cnt_zero = (r_asm_st == A_COLLECT && (r_frame_err || (w_acc && !w_term && w_full_buf))) ||
                 (r_asm_st == A_HOLD && bus.msg_ack);
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_count     <= 5'd0;
      r_len       <= 5'd0;
      r_msg_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_rd_data   <= 8'h00;
    end else begin
      r_count     <= w_cnt_zero ? 5'd0 : r_count + 5'(w_wr);
      r_len       <= w_latch ? r_count : r_len;
      r_msg_valid <= w_latch ? 1'b1 : (r_asm_st == A_HOLD && bus.msg_ack) ? 1'b0 : r_msg_valid;
      r_ovf       <= w_ovf;
      r_rd_data   <= bus.msg_rd_addr < MAX_C ? r_buf[bus.msg_rd_addr] : 8'h00;
    end
  end
  always_ff @(posedge clk_50M) begin
    if (w_wr) r_buf[r_count] <= r_byte;
  end
  assign bus.rx_byte       = r_byte;
  assign bus.rx_byte_valid = r_byte_valid;
  assign bus.frame_err     = r_frame_err;
  assign bus.overflow_err  = r_ovf;
  assign bus.msg_valid     = r_msg_valid;
  assign bus.msg_len       = r_len;
  assign bus.msg_rd_data   = r_rd_data;
endmodule

// File: tb/tb_bt_msg_receiver.sv
// tb_bt_msg_receiver: directed UART stimulus with a byte scoreboard and message buffer checks
module tb_bt_msg_receiver;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid = 0;
  int t_start = 0;
  int rx_cnt = 0, fe_cnt = 0, ovf_cnt = 0, mv_rise = 0;
  logic mv_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bt_msg_receiver_if bus();
  bt_msg_receiver #(.CLKS_PER_BIT(CPB), .MAX_LEN(16), .TERM_CHAR(8'h23)) dut (
    .clk_50M(clk),
    .rst(rst),
    .bus(bus)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.rx_byte_valid) begin
      got_q.push_back(bus.rx_byte);
      rx_cnt++;
      last_valid = cyc;
    end
    if (bus.frame_err) fe_cnt++;
    if (bus.overflow_err) ovf_cnt++;
    if (bus.msg_valid && !mv_prev) mv_rise++;
    mv_prev = bus.msg_valid;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    if (stop_bit) exp_q.push_back(b);
    t_start = cyc;
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic drain(input string tag);
    logic [7:0] e, g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk(tag, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
    bus.msg_rd_addr = a;
    @(negedge clk);
    @(negedge clk);
    chk(tag, bus.msg_rd_data, exp);
  endtask
  task automatic wait_mv(input logic lvl, input string tag);
    int n = 0;
    while (bus.msg_valid !== lvl && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.msg_valid, lvl);
  endtask
  task automatic ack(input string tag);
    bus.msg_ack = 1'b1;
    @(negedge clk);
    bus.msg_ack = 1'b0;
    chk(tag, bus.msg_valid, 1'b0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_byte"}, bus.rx_byte, 8'h00);
    chk({tag, "_rx_valid"}, bus.rx_byte_valid, 1'b0);
    chk({tag, "_frame_err"}, bus.frame_err, 1'b0);
    chk({tag, "_ovf"}, bus.overflow_err, 1'b0);
    chk({tag, "_msg_valid"}, bus.msg_valid, 1'b0);
    chk({tag, "_msg_len"}, bus.msg_len, 5'd0);
    chk({tag, "_rd_data"}, bus.msg_rd_data, 8'h00);
  endtask
  initial begin
    int fe0, ovf0, mv0, rx0;
    bus.uart_rx = 1'b1;
    bus.msg_rd_addr = 5'd0;
    bus.msg_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    // single byte, latency about 9.5 bit times plus synchroniser delay
    fe0 = fe_cnt;
    send_byte(8'h41);
    chk("t1_latency_ok", ((last_valid - t_start) >= 9 * CPB) && ((last_valid - t_start) <= 10 * CPB + 4), 1'b1);
    chk("t1_no_frame_err", fe_cnt - fe0, 0);
    send_byte(8'h23);
    drain("t1_byte");
    wait_mv(1'b1, "t1_msg_valid");
    chk("t1_msg_len", bus.msg_len, 5'd1);
    rd(5'd0, 8'h41, "t1_buf0");
    ack("t1_ack");
    // "FIM-#"
    send_str("FIM-#");
    drain("t2_bytes");
    wait_mv(1'b1, "t2_msg_valid");
    chk("t2_msg_len", bus.msg_len, 5'd4);
    rd(5'd0, 8'h46, "t2_buf0");
    rd(5'd1, 8'h49, "t2_buf1");
    rd(5'd2, 8'h4D, "t2_buf2");
    rd(5'd3, 8'h2D, "t2_buf3");
    rd(5'd20, 8'h00, "t2_addr_oob");
    ack("t2_ack");
    // glitch shorter than half a bit
    rx0 = rx_cnt;
    fe0 = fe_cnt;
    bus.uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t3_glitch_no_byte", rx_cnt - rx0, 0);
    chk("t3_glitch_no_fe", fe_cnt - fe0, 0);
    send_byte(8'h55);
    send_byte(8'h23);
    drain("t3_bytes");
    wait_mv(1'b1, "t3_msg_valid");
    chk("t3_msg_len", bus.msg_len, 5'd1);
    rd(5'd0, 8'h55, "t3_buf0");
    ack("t3_ack");
    // framing error aborts the partial message
    fe0 = fe_cnt;
    send_str("AB");
    send_byte(8'h7E, 1'b0);
    send_str("C#");
    drain("t4_bytes");
    chk("t4_frame_err_once", fe_cnt - fe0, 1);
    wait_mv(1'b1, "t4_msg_valid");
    chk("t4_msg_len", bus.msg_len, 5'd1);
    rd(5'd0, 8'h43, "t4_buf0");
    ack("t4_ack");
    // overflow past MAX_LEN discards the whole message
    ovf0 = ovf_cnt;
    mv0 = mv_rise;
    for (int i = 0; i < 17; i++) send_byte(8'h5A);
    send_byte(8'h23);
    repeat (4) @(negedge clk);
    drain("t5_bytes");
    chk("t5_ovf_once", ovf_cnt - ovf0, 1);
    chk("t5_no_msg", mv_rise - mv0, 0);
    send_str("OK#");
    drain("t5_ok_bytes");
    wait_mv(1'b1, "t5_msg_valid");
    chk("t5_msg_len", bus.msg_len, 5'd2);
    rd(5'd0, 8'h4F, "t5_buf0");
    rd(5'd1, 8'h4B, "t5_buf1");
    // bytes while held are dropped; held data survives
    ovf0 = ovf_cnt;
    send_str("X#");
    repeat (4) @(negedge clk);
    drain("t6_bytes");
    chk("t6_ovf_twice", ovf_cnt - ovf0, 2);
    chk("t6_still_valid", bus.msg_valid, 1'b1);
    chk("t6_len_kept", bus.msg_len, 5'd2);
    rd(5'd0, 8'h4F, "t6_buf0");
    rd(5'd1, 8'h4B, "t6_buf1");
    // reset mid-byte
    bus.uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    bus.uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'hA6);
    drain("t6_after_rst");
    chk("t6_after_rst_no_msg", bus.msg_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
